// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and access sequencer for a single-port data memory.
// Handles byte/half/word loads and stores with lane merge, alignment and range checks.
module dmem_arbiter #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [1:0]        m0_size,
  input  logic [31:0]       m0_addr,
  input  logic [31:0]       m0_wdata,
  output logic              m0_ack,
  output logic              m0_err,
  output logic [31:0]       m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [1:0]        m1_size,
  input  logic [31:0]       m1_addr,
  input  logic [31:0]       m1_wdata,
  output logic              m1_ack,
  output logic              m1_err,
  output logic [31:0]       m1_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_data,
  output logic              mem_wren,
  input  logic [31:0]       mem_q,
  output logic              busy
);

  localparam int unsigned RANGE_SH = ADDR_W + 2;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t state, state_nx;

  logic        rr_ptr;
  logic        lat_id, lat_we, lat_err;
  logic [1:0]  lat_size, lat_lane;
  logic [31:0] lat_wdata;

  logic        any_req, grant, latch;
  logic        sel_we, sel_err;
  logic [1:0]  sel_size;
  logic [31:0] sel_addr, sel_wdata;
  logic [4:0]  sh_byte, sh_half;
  logic [31:0] shifted, rd_val, merged;

  // Winner selection: a lone requester wins, a tie goes to the port the pointer favours.
  always_comb begin
    any_req   = m0_req | m1_req;
    grant     = (m0_req & m1_req) ? rr_ptr : (m1_req & ~m0_req);
    latch     = (state == IDLE) & any_req;
    sel_we    = grant ? m1_we    : m0_we;
    sel_size  = grant ? m1_size  : m0_size;
    sel_addr  = grant ? m1_addr  : m0_addr;
    sel_wdata = grant ? m1_wdata : m0_wdata;
    sel_err   = (sel_size == 2'b11)
              | ((sel_size == 2'b01) & sel_addr[0])
              | ((sel_size == 2'b10) & (sel_addr[1:0] != 2'b00))
              | ((sel_addr >> RANGE_SH) != 32'd0);
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (any_req) state_nx = ACCESS;
      ACCESS:  state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Lane extraction for loads and read-modify-write merge for sub-word stores.
  always_comb begin
    sh_byte = {lat_lane, 3'b000};
    sh_half = {lat_lane[1], 4'b0000};
    shifted = mem_q >> sh_byte;
    case (lat_size)
      2'b00:   rd_val = {24'd0, shifted[7:0]};
      2'b01:   rd_val = {16'd0, shifted[15:0]};
      default: rd_val = mem_q;
    endcase
    case (lat_size)
      2'b00:   merged = (mem_q & ~(32'h0000_00FF << sh_byte)) | (32'(lat_wdata[7:0]) << sh_byte);
      2'b01:   merged = (mem_q & ~(32'h0000_FFFF << sh_half)) | (32'(lat_wdata[15:0]) << sh_half);
      default: merged = lat_wdata;
    endcase
  end

  assign mem_wren = (state == ACCESS) & lat_we & ~lat_err & ~reset;
  assign mem_data = (state == ACCESS) ? merged : 32'd0;
  assign busy     = (state != IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr      <= 1'b0;
      lat_id      <= 1'b0;
      lat_we      <= 1'b0;
      lat_err     <= 1'b0;
      lat_size    <= 2'b00;
      lat_lane    <= 2'b00;
      lat_wdata   <= 32'd0;
      mem_address <= '0;
      m0_ack      <= 1'b0;
      m0_err      <= 1'b0;
      m0_rdata    <= 32'd0;
      m1_ack      <= 1'b0;
      m1_err      <= 1'b0;
      m1_rdata    <= 32'd0;
    end else begin
      m0_ack <= 1'b0;
      m0_err <= 1'b0;
      m1_ack <= 1'b0;
      m1_err <= 1'b0;
      if (latch) begin
        rr_ptr      <= ~grant;
        lat_id      <= grant;
        lat_we      <= sel_we;
        lat_err     <= sel_err;
        lat_size    <= sel_size;
        lat_lane    <= sel_addr[1:0];
        lat_wdata   <= sel_wdata;
        mem_address <= sel_addr[ADDR_W+1:2];
      end
      // Result captured at the end of ACCESS so ack and rdata appear together in RESP.
      if (state == ACCESS) begin
        if (lat_id) begin
          m1_ack   <= 1'b1;
          m1_err   <= lat_err;
          m1_rdata <= lat_err ? 32'd0 : rd_val;
        end else begin
          m0_ack   <= 1'b1;
          m0_err   <= lat_err;
          m0_rdata <= lat_err ? 32'd0 : rd_val;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed vector table, contention and reset
// sequences, and random traffic checked against a byte-addressed memory model.
module tb_dmem_arbiter;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned NWORDS = 256;

  logic clock = 1'b0, reset = 1'b1;
  logic m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [1:0] m0_size = 0, m1_size = 0;
  logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
  logic m0_ack, m0_err, m1_ack, m1_err, mem_wren, busy;
  logic [31:0] m0_rdata, m1_rdata, mem_data, mem_q;
  logic [ADDR_W-1:0] mem_address;

  logic [31:0] mem [NWORDS];
  logic [7:0]  ref_b [NWORDS*4];
  logic        preload = 1'b0;
  logic [7:0]  preload_idx = 0;
  logic [31:0] preload_word = 0;
  logic        last_grant = 1'b1;
  int tests = 0, fails = 0;

  always #5 clock = ~clock;

  dmem_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_size(m0_size), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_size(m1_size), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q),
    .busy(busy)
  );

  assign mem_q = mem[mem_address];
  always @(posedge clock) begin
    if (preload) mem[preload_idx] <= preload_word;
    else if (mem_wren) mem[mem_address] <= mem_data;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic model_err(input logic [1:0] size, input logic [31:0] addr);
    return (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 0)
           || (addr >= 32'(NWORDS * 4));
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [1:0] size);
    logic [31:0] r = 0;
    for (int i = 0; i < (1 << size); i++) r = r | (32'(ref_b[addr[9:0] + 10'(i)]) << (8 * i));
    return r;
  endfunction

  function automatic logic [31:0] ref_word(input logic [7:0] idx);
    return {ref_b[{idx, 2'd3}], ref_b[{idx, 2'd2}], ref_b[{idx, 2'd1}], ref_b[{idx, 2'd0}]};
  endfunction

  task automatic model_store(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] wd);
    for (int i = 0; i < (1 << size); i++) ref_b[addr[9:0] + 10'(i)] = wd[8*i +: 8];
  endtask

  task automatic drive(input logic port, input logic req, input logic we, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] wd);
    if (port) begin m1_req = req; m1_we = we; m1_size = size; m1_addr = addr; m1_wdata = wd; end
    else      begin m0_req = req; m0_we = we; m0_size = size; m0_addr = addr; m0_wdata = wd; end
  endtask

  // One access on one port, called at a negedge with the arbiter idle.
  task automatic run_access(input string nm, input logic port, input logic we, input logic [1:0] size,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input logic exp_err, input logic [31:0] exp_rd);
    int cyc = 0;
    logic wren_seen = 0, other_ack = 0, ack_seen = 0;
    logic [31:0] rd = 0;
    logic er = 0;
    drive(port, 1'b1, we, size, addr, wd);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clock);
      wren_seen |= mem_wren;
      other_ack |= port ? m0_ack : m1_ack;
      if (c == 1) check({nm, "_addr"}, 32'(mem_address), 32'(addr[9:2]));
      if (port ? m1_ack : m0_ack) begin
        cyc = c; ack_seen = 1;
        er = port ? m1_err : m0_err;
        rd = port ? m1_rdata : m0_rdata;
        break;
      end
    end
    drive(port, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
    check({nm, "_latency"}, 32'(cyc), 32'd2);
    check({nm, "_err"}, 32'(er), 32'(exp_err));
    if (!we || exp_err) check({nm, "_rdata"}, rd, exp_rd);
    check({nm, "_wren"}, 32'(wren_seen), 32'(we & ~exp_err));
    check({nm, "_other_ack"}, 32'(other_ack), 32'd0);
    if (ack_seen) last_grant = port;
    if (we && !exp_err) model_store(addr, size, wd);
    @(negedge clock);
    check({nm, "_mem"}, mem[addr[9:2]], ref_word(addr[9:2]));
  endtask

  // Both ports request word loads in the same cycle; the port not granted last goes first.
  task automatic contend(input string nm, input logic [31:0] a0, input logic [31:0] a1);
    logic first = ~last_grant;
    int c0 = 0, c1 = 0;
    logic [31:0] e0 = model_load(a0, 2'd2), e1 = model_load(a1, 2'd2);
    drive(1'b0, 1'b1, 1'b0, 2'd2, a0, 32'd0);
    drive(1'b1, 1'b1, 1'b0, 2'd2, a1, 32'd0);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clock);
      if (m0_ack && c0 == 0) begin
        c0 = c; check({nm, "_rd0"}, m0_rdata, e0); drive(1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
      end
      if (m1_ack && c1 == 0) begin
        c1 = c; check({nm, "_rd1"}, m1_rdata, e1); drive(1'b1, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
      end
      if (c0 != 0 && c1 != 0) break;
    end
    drive(1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
    check({nm, "_m0_cycle"}, 32'(c0), first ? 32'd5 : 32'd2);
    check({nm, "_m1_cycle"}, 32'(c1), first ? 32'd2 : 32'd5);
    last_grant = ~first;
    @(negedge clock);
  endtask

  typedef struct {
    logic        port;
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs [14];

  initial begin
    logic [31:0] w, a, old;
    logic p, we;
    logic [1:0] sz;

    vecs[0]  = '{0, 1, 2'd2, 32'h10,  32'hDEADBEEF, 0, 32'h0};
    vecs[1]  = '{0, 0, 2'd2, 32'h10,  32'h0,        0, 32'hDEADBEEF};
    vecs[2]  = '{0, 1, 2'd0, 32'h12,  32'h000000AA, 0, 32'h0};
    vecs[3]  = '{0, 0, 2'd2, 32'h10,  32'h0,        0, 32'hDEAABEEF};
    vecs[4]  = '{0, 1, 2'd1, 32'h10,  32'h00001234, 0, 32'h0};
    vecs[5]  = '{0, 0, 2'd2, 32'h10,  32'h0,        0, 32'hDEAA1234};
    vecs[6]  = '{0, 0, 2'd0, 32'h13,  32'h0,        0, 32'h000000DE};
    vecs[7]  = '{1, 0, 2'd1, 32'h12,  32'h0,        0, 32'h0000DEAA};
    vecs[8]  = '{1, 1, 2'd2, 32'h11,  32'h11111111, 1, 32'h0};
    vecs[9]  = '{1, 1, 2'd1, 32'h13,  32'h00002222, 1, 32'h0};
    vecs[10] = '{0, 1, 2'd3, 32'h10,  32'h33333333, 1, 32'h0};
    vecs[11] = '{0, 1, 2'd2, 32'h400, 32'h44444444, 1, 32'h0};
    vecs[12] = '{1, 0, 2'd2, 32'h10,  32'h0,        0, 32'hDEAA1234};
    vecs[13] = '{0, 0, 2'd0, 32'h400, 32'h0,        1, 32'h0};

    // Preload harness memory and model with the same random contents while in reset.
    for (int i = 0; i < int'(NWORDS * 4); i++) ref_b[i] = 8'($urandom);
    preload = 1;
    for (int i = 0; i < int'(NWORDS); i++) begin
      preload_idx = 8'(i);
      preload_word = ref_word(8'(i));
      @(negedge clock);
    end
    preload = 0;
    reset = 0;

    check("rst_busy", 32'(busy), 32'd0);
    check("rst_acks", {28'd0, m0_ack, m0_err, m1_ack, m1_err}, 32'd0);
    check("rst_m0_rdata", m0_rdata, 32'd0);
    check("rst_m1_rdata", m1_rdata, 32'd0);
    check("rst_mem_if", {23'd0, mem_wren, mem_address}, 32'd0);
    check("rst_mem_data", mem_data, 32'd0);

    contend("arb_a", 32'h20, 32'h24);
    contend("arb_b", 32'h28, 32'h2C);
    run_access("arb_solo", 1'b0, 1'b0, 2'd2, 32'h30, 32'h0, 1'b0, model_load(32'h30, 2'd2));
    contend("arb_c", 32'h34, 32'h38);

    for (int i = 0; i < 14; i++)
      run_access($sformatf("vec%0d", i), vecs[i].port, vecs[i].we, vecs[i].size,
                 vecs[i].addr, vecs[i].wdata, vecs[i].err, vecs[i].rdata);

    for (int i = 0; i < 60; i++) begin
      p  = 1'($urandom);
      we = 1'($urandom);
      sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a  = 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 3) != 0 && sz != 2'd3) a = a & ~((32'd1 << sz) - 32'd1);
      if ($urandom_range(0, 9) == 0) a = a | 32'h0000_0400 << $urandom_range(0, 21);
      w = $urandom;
      if (i % 10 == 9) contend($sformatf("rnd_arb%0d", i), {a[9:2], 2'b00} & 32'h3FC, 32'h3FC - {a[9:2], 2'b00});
      else run_access($sformatf("rnd%0d", i), p, we, sz, a, w, model_err(sz, a),
                      model_err(sz, a) ? 32'd0 : model_load(a, sz));
    end

    // Reset lands during the ACCESS cycle of a store: no write, no ack.
    old = ref_word(8'h10);
    drive(1'b0, 1'b1, 1'b1, 2'd2, 32'h40, ~old);
    @(negedge clock);
    check("rstmid_busy_access", 32'(busy), 32'd1);
    reset = 1;
    #1;
    check("rstmid_wren", 32'(mem_wren), 32'd0);
    @(negedge clock);
    drive(1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_acks", {28'd0, m0_ack, m0_err, m1_ack, m1_err}, 32'd0);
    check("rstmid_rdata", m0_rdata | m1_rdata, 32'd0);
    check("rstmid_mem_if", {23'd0, mem_wren, mem_address}, 32'd0);
    check("rstmid_mem_data", mem_data, 32'd0);
    check("rstmid_word", mem[8'h10], old);
    reset = 0;
    @(negedge clock);
    check("rstmid_no_late_ack", {30'd0, m0_ack, m1_ack}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
